// File: rtl/dmem_lsu.sv
// Word-organised data memory behind a RISC-V byte/half/word load/store front end,
// with a post-reset zero-fill sequence and a fixed-latency valid/ready response path.
module dmem_lsu #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LAT_W  = $clog2(LATENCY + 1);

    localparam logic [IDX_W-1:0]  DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [MEM_AW-1:0] LAST_WORD = MEM_AW'(DEPTH - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_BUSY = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [MEM_AW-1:0]  clr_cnt_q, clr_cnt_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [31:0]        hold_rdata_q, hold_rdata_d;
    logic               hold_err_q, hold_err_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [31:0]        mem_q [DEPTH];

    logic [IDX_W-1:0]   word_idx;
    logic [1:0]         lane;
    logic               in_range;
    logic               f3_ok;
    logic               aligned;
    logic               req_err;
    logic [MEM_AW-1:0]  acc_idx;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        ld_data;
    logic [3:0]         st_be;
    logic [31:0]        st_data;
    logic [31:0]        result_rdata;

    logic               accept;
    logic               mem_we;
    logic [3:0]         mem_be;
    logic [MEM_AW-1:0]  mem_widx;
    logic [31:0]        mem_wdata;

    // Request decode: range/alignment/funct3 checks, load extraction, store lane merge
    always_comb begin
        word_idx = req_addr_i[ADDR_W-1:2];
        lane     = req_addr_i[1:0];
        in_range = (word_idx < DEPTH_IDX);
        acc_idx  = in_range ? MEM_AW'(word_idx) : '0;

        if (req_we_i) begin
            f3_ok = (req_funct3_i <= 3'd2);
        end else begin
            f3_ok = (req_funct3_i != 3'd3) && (req_funct3_i <= 3'd5);
        end

        unique case (req_funct3_i[1:0])
            2'd1:    aligned = ~req_addr_i[0];
            2'd2:    aligned = (req_addr_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        req_err = ~f3_ok | ~aligned | ~in_range;

        rd_word = mem_q[acc_idx];
        rd_byte = rd_word[8*lane +: 8];
        rd_half = rd_word[16*lane[1] +: 16];

        unique case (req_funct3_i)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'h0, rd_byte};
            3'b101:  ld_data = {16'h0, rd_half};
            default: ld_data = '0;
        endcase

        unique case (req_funct3_i[1:0])
            2'd0: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                st_be   = 4'b0011 << {lane[1], 1'b0};
                st_data = {2{req_wdata_i[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = req_wdata_i;
            end
        endcase

        result_rdata = (req_err || req_we_i) ? '0 : ld_data;
    end

    // Next-state, memory write port and response scheduling
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        hold_rdata_d = hold_rdata_q;
        hold_err_d   = hold_err_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        mem_we       = 1'b0;
        mem_be       = '0;
        mem_widx     = clr_cnt_q;
        mem_wdata    = '0;
        accept       = 1'b0;

        unique case (state_q)
            S_INIT: begin
                mem_we = 1'b1;
                mem_be = 4'b1111;
                if (clr_cnt_q == LAST_WORD) begin
                    state_d = S_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                accept = req_valid_i && req_ready_q;
                if (accept) begin
                    if (!req_err && req_we_i) begin
                        mem_we    = 1'b1;
                        mem_be    = st_be;
                        mem_widx  = acc_idx;
                        mem_wdata = st_data;
                    end
                    if (LATENCY == 1) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = result_rdata;
                        rsp_err_d   = req_err;
                    end else begin
                        state_d      = S_BUSY;
                        lat_cnt_d    = LAT_W'(1);
                        hold_rdata_d = result_rdata;
                        hold_err_d   = req_err;
                    end
                end
            end
            S_BUSY: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = hold_rdata_q;
                    rsp_err_d   = hold_err_q;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_INIT;
            clr_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            hold_rdata_q <= '0;
            hold_err_q   <= 1'b0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            hold_rdata_q <= hold_rdata_d;
            hold_err_q   <= hold_err_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Storage array has no reset; INIT zero-fills it after every reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: two instances (DEPTH=16/LATENCY=1 and DEPTH=5/LATENCY=3)
// checked against a byte-addressed reference memory.
module tb_dmem_lsu;

    localparam int unsigned D0 = 16;
    localparam int unsigned D1 = 5;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [2:0]  req_f3    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [7:0]  mbytes [2][64];

    int checks = 0;
    int failures = 0;
    int run [2] = '{0, 0};
    int max_run [2] = '{0, 0};
    int rsp_cnt [2] = '{0, 0};
    int wait_cycles = 0;

    dmem_lsu #(.ADDR_W(32), .DEPTH(D0), .LATENCY(1)) u_dut0 (
        .clk(clk), .reset_n(rst_n[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_we_i(req_we[0]), .req_funct3_i(req_f3[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
    );

    dmem_lsu #(.ADDR_W(32), .DEPTH(D1), .LATENCY(3)) u_dut1 (
        .clk(clk), .reset_n(rst_n[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_we_i(req_we[1]), .req_funct3_i(req_f3[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    // Reference: memory as plain bytes, little-endian; loads assemble n bytes and extend
    task automatic model(input int d, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err);
        int unsigned dep;
        int unsigned n;
        logic [31:0] v;
        dep = (d == 0) ? D0 : D1;
        n   = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        err = 1'b0;
        if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) err = 1'b1;
        if (addr % n != 0) err = 1'b1;
        if ((addr >> 2) >= 32'(dep)) err = 1'b1;
        rd = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < int'(n); i++) mbytes[d][addr + 32'(i)] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < int'(n); i++) v = v | (32'(mbytes[d][addr + 32'(i)]) << (8*i));
                if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                rd = v;
            end
        end
    endtask

    task automatic issue(input int d, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input bit use_c = 1'b0, input logic [31:0] c_rd = '0,
                         input logic c_err = 1'b0);
        exp_t e;
        int   waitc;
        waitc = 0;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_f3[d]    = f3;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        while (req_ready[d] !== 1'b1) begin
            @(negedge clk);
            waitc++;
            wait_cycles++;
            if (waitc > 200) begin
                chk("accept_timeout", 32'(req_ready[d]), 32'd1);
                req_valid[d] = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model(d, we, f3, addr, wd, e.rd, e.err);
        if (use_c) begin
            e.rd  = c_rd;
            e.err = c_err;
        end
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        req_valid[d] = 1'b0;
    endtask

    // Assert reset, check reset outputs, release and measure the INIT length
    task automatic reset_init(input int d);
        int n;
        int unsigned dep;
        dep = (d == 0) ? D0 : D1;
        @(negedge clk);
        rst_n[d]     = 1'b0;
        req_valid[d] = 1'b0;
        if (d == 0) q0.delete();
        else        q1.delete();
        #1;
        chk($sformatf("rst%0d_ready", d), 32'(req_ready[d]), 32'd0);
        chk($sformatf("rst%0d_valid", d), 32'(rsp_valid[d]), 32'd0);
        repeat (3) @(negedge clk);
        chk($sformatf("rst%0d_rdata", d), rsp_rdata[d], 32'd0);
        chk($sformatf("rst%0d_err", d), 32'(rsp_err[d]), 32'd0);
        rst_n[d] = 1'b1;
        for (int i = 0; i < 64; i++) mbytes[d][i] = 8'h00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready[d] !== 1'b1 && n < int'(dep) + 50);
        chk($sformatf("init%0d_cycles", d), 32'(n), 32'(dep));
    endtask

    task automatic rand_ops(input int d, input int cnt);
        int unsigned dep;
        logic [31:0] a;
        dep = (d == 0) ? D0 : D1;
        for (int k = 0; k < cnt; k++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else                           a = 32'($urandom_range(0, 4*dep + 7));
            issue(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle(d);
        end
        idle(d);
    endtask

    // Monitor: pop one expectation per response pulse
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] === 1'b1) begin
                rsp_cnt[d]++;
                run[d]++;
                if (run[d] > max_run[d]) max_run[d] = run[d];
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp%0d_unexpected rdata=%h err=%b expected no response",
                             d, rsp_rdata[d], rsp_err[d]);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("rsp%0d_rdata", d), rsp_rdata[d], e.rd);
                    chk($sformatf("rsp%0d_err", d), 32'(rsp_err[d]), 32'(e.err));
                end
            end else begin
                run[d] = 0;
            end
        end
    end

    initial begin
        int rc;
        int wc;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            req_valid[d] = 1'b0;
            req_we[d] = 1'b0;
            req_f3[d] = 3'd0;
            req_addr[d] = '0;
            req_wdata[d] = '0;
        end
        repeat (2) @(negedge clk);
        reset_init(0);
        reset_init(1);

        // Zero-filled after INIT
        for (int w = 0; w < int'(D0); w++) issue(0, 1'b0, 3'b010, 32'(4*w), '0, 1'b1, 32'h0, 1'b0);

        issue(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        issue(0, 1'b0, 3'b000, 32'h13, '0, 1'b1, 32'hFFFFFFDE, 1'b0);
        issue(0, 1'b0, 3'b100, 32'h13, '0, 1'b1, 32'h000000DE, 1'b0);
        issue(0, 1'b0, 3'b001, 32'h12, '0, 1'b1, 32'hFFFFDEAD, 1'b0);
        issue(0, 1'b0, 3'b101, 32'h10, '0, 1'b1, 32'h0000BEEF, 1'b0);

        issue(0, 1'b1, 3'b010, 32'h20, 32'h11223344, 1'b1, 32'h0, 1'b0);
        issue(0, 1'b1, 3'b000, 32'h21, 32'hFFFFFFAA, 1'b1, 32'h0, 1'b0);
        issue(0, 1'b1, 3'b001, 32'h22, 32'hFFFF5566, 1'b1, 32'h0, 1'b0);
        issue(0, 1'b0, 3'b010, 32'h20, '0, 1'b1, 32'h5566AA44, 1'b0);

        // Faulting requests, then verify targeted words unchanged
        issue(0, 1'b0, 3'b001, 32'h01, '0, 1'b1, 32'h0, 1'b1);
        issue(0, 1'b1, 3'b010, 32'h22, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
        issue(0, 1'b0, 3'b010, 32'(4*D0), '0, 1'b1, 32'h0, 1'b1);
        issue(0, 1'b0, 3'b011, 32'h20, '0, 1'b1, 32'h0, 1'b1);
        issue(0, 1'b0, 3'b010, 32'h00, '0, 1'b1, 32'h0, 1'b0);
        issue(0, 1'b0, 3'b010, 32'h20, '0, 1'b1, 32'h5566AA44, 1'b0);

        // LATENCY=1 back-to-back: 8 accepts without stalls, 8 consecutive responses
        idle(0);
        repeat (2) @(negedge clk);
        max_run[0] = 0;
        rc = rsp_cnt[0];
        wc = wait_cycles;
        for (int k = 0; k < 8; k++) issue(0, 1'b0, 3'b010, 32'(4*k), '0);
        idle(0);
        @(negedge clk);
        chk("b2b_stalls", 32'(wait_cycles - wc), 32'd0);
        chk("b2b_rsp_count", 32'(rsp_cnt[0] - rc), 32'd8);
        chk("b2b_rsp_run", 32'(max_run[0]), 32'd8);

        rand_ops(0, 200);

        // LATENCY=3 timing
        issue(1, 1'b1, 3'b010, 32'h04, 32'h12345678, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("lat3_c1_ready", 32'(req_ready[1]), 32'd0);
        chk("lat3_c1_valid", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        chk("lat3_c2_ready", 32'(req_ready[1]), 32'd0);
        chk("lat3_c2_valid", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        chk("lat3_c3_ready", 32'(req_ready[1]), 32'd1);
        chk("lat3_c3_valid", 32'(rsp_valid[1]), 32'd1);
        issue(1, 1'b0, 3'b010, 32'h04, '0, 1'b1, 32'h12345678, 1'b0);
        issue(1, 1'b0, 3'b010, 32'(4*D1), '0, 1'b1, 32'h0, 1'b1);
        idle(1);
        rand_ops(1, 60);
        repeat (4) @(negedge clk);

        // Reset one cycle after a LATENCY=3 accept drops the response
        rc = rsp_cnt[1];
        issue(1, 1'b0, 3'b010, 32'h04, '0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        reset_init(1);
        chk("midbusy_no_rsp", 32'(rsp_cnt[1] - rc), 32'd0);
        for (int w = 0; w < int'(D1); w++) issue(1, 1'b0, 3'b010, 32'(4*w), '0, 1'b1, 32'h0, 1'b0);
        idle(1);

        for (int k = 0; k < 50 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
